// File: rtl/sdcard_ctrl_pkg.sv
// Shared sizes, write-FSM states and FIFO tag layout for the sector FIFO controller.
package sdcard_ctrl_pkg;

    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned AW       = 10;
    localparam int unsigned SECTOR   = 512;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned LEVEL_W  = AW + 1;
    localparam int unsigned ROOM_MAX = DEPTH - SECTOR;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROOM,
        REQ,
        STREAM,
        DONE
    } wrState_t;

    typedef struct packed {
        logic full;
        logic empty;
    } fifoTag_t;

endpackage

// File: rtl/xfer_skidmod.sv
// Two-entry output buffer that prefetches from the save FIFO and hides its one-cycle read latency.
module xfer_skidmod
    import sdcard_ctrl_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              iAvail,
    input  logic [BYTE_W-1:0] iData,
    input  logic              iReady,
    output logic              oRdEn_c,
    output logic [BYTE_W-1:0] oData,
    output logic              oValid
);

    logic [BYTE_W-1:0] headQ;
    logic [BYTE_W-1:0] tailQ;
    logic [1:0]        occ;
    logic              inFlight;
    logic              pop;
    logic [1:0]        committed;

    assign oValid    = (occ != 2'd0);
    assign oData     = headQ;
    assign pop       = oValid && iReady;
    // Slots already claimed after this cycle's pop; a new read may only target a free slot.
    assign committed = occ + 2'(inFlight) - 2'(pop);
    assign oRdEn_c   = iAvail && (committed < 2'd2);

    // Capture the in-flight byte behind any remaining entry and shift on pop.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            headQ    <= '0;
            tailQ    <= '0;
            occ      <= 2'd0;
            inFlight <= 1'b0;
        end else begin
            inFlight <= oRdEn_c;
            case ({inFlight, pop})
                2'b01: begin
                    headQ <= tailQ;
                    occ   <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) begin
                        headQ <= iData;
                    end else begin
                        tailQ <= iData;
                    end
                    occ <= occ + 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        headQ <= iData;
                    end else begin
                        headQ <= tailQ;
                        tailQ <= iData;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sector_fifo_ctrlmod.sv
// Admits one SD sector into the save FIFO when it fits whole, and drains the FIFO to a valid/ready consumer.
module sector_fifo_ctrlmod
    import sdcard_ctrl_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              iCall,
    output logic              oDone,
    output logic              oSdCall,
    input  logic [BYTE_W-1:0] iSdData,
    input  logic              iSdValid,
    output logic [1:0]        oFifoEn,
    output logic [BYTE_W-1:0] oFifoData,
    input  logic [BYTE_W-1:0] iFifoData,
    input  logic [1:0]        iFifoTag,
    output logic [BYTE_W-1:0] oData,
    output logic              oValid,
    input  logic              iReady,
    output logic [AW:0]       oLevel,
    output logic              oErr
);

    wrState_t           state;
    wrState_t           nextState;
    logic [AW-1:0]      byteCnt;
    logic [LEVEL_W-1:0] level;
    logic               sdCallReg;
    logic               errReg;
    fifoTag_t           tag;
    logic               sdStrobe;
    logic               lastByte;
    logic               wrEn;
    logic               rdEn;
    logic               fifoAvail;

    assign tag       = fifoTag_t'(iFifoTag);
    assign sdStrobe  = (state == STREAM) && iSdValid;
    assign lastByte  = sdStrobe && (byteCnt == AW'(SECTOR - 1));
    assign wrEn      = sdStrobe && !tag.full;
    assign fifoAvail = (level != '0) && !tag.empty;

    assign oFifoEn   = {wrEn, rdEn};
    assign oFifoData = iSdData;
    assign oDone     = (state == DONE);
    assign oSdCall   = sdCallReg;
    assign oLevel    = level;
    assign oErr      = errReg;

    // Write-FSM state register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: wait for a whole sector of room, request, stream, then pulse done.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (iCall) nextState = WAIT_ROOM;
            WAIT_ROOM: if (level <= LEVEL_W'(ROOM_MAX)) nextState = REQ;
            REQ:       nextState = STREAM;
            STREAM:    if (lastByte) nextState = DONE;
            DONE:      nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // Byte counter, SD request flag (REQ until first strobe) and sticky overflow error.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            byteCnt   <= '0;
            sdCallReg <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            if (sdStrobe) begin
                byteCnt <= lastByte ? '0 : byteCnt + AW'(1);
            end
            if ((state == WAIT_ROOM) && (nextState == REQ)) begin
                sdCallReg <= 1'b1;
            end else if (sdStrobe) begin
                sdCallReg <= 1'b0;
            end
            if (sdStrobe && tag.full) begin
                errReg <= 1'b1;
            end
        end
    end

    // Bytes held in the FIFO that have not yet been read out.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            level <= '0;
        end else begin
            case ({wrEn, rdEn})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

    xfer_skidmod uSkid (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .iAvail  (fifoAvail),
        .iData   (iFifoData),
        .iReady  (iReady),
        .oRdEn_c (rdEn),
        .oData   (oData),
        .oValid  (oValid)
    );

endmodule

// File: tb/tb_sector_fifo_ctrlmod.sv
// Self-checking bench: save-FIFO model, table-driven FSM vectors and multi-cycle sector sequences.
module tb_sector_fifo_ctrlmod;
    import sdcard_ctrl_pkg::*;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        iCall = 1'b0;
    logic        oDone;
    logic        oSdCall;
    logic [7:0]  iSdData = 8'h00;
    logic        iSdValid = 1'b0;
    logic [1:0]  oFifoEn;
    logic [7:0]  oFifoData;
    logic [7:0]  iFifoData;
    logic [1:0]  iFifoTag;
    logic [7:0]  oData;
    logic        oValid;
    logic        iReady = 1'b0;
    logic [10:0] oLevel;
    logic        oErr;

    always #5 CLOCK = ~CLOCK;

    sector_fifo_ctrlmod dut (
        .CLOCK(CLOCK), .RESET(RESET), .iCall(iCall), .oDone(oDone), .oSdCall(oSdCall),
        .iSdData(iSdData), .iSdValid(iSdValid), .oFifoEn(oFifoEn), .oFifoData(oFifoData),
        .iFifoData(iFifoData), .iFifoTag(iFifoTag), .oData(oData), .oValid(oValid),
        .iReady(iReady), .oLevel(oLevel), .oErr(oErr)
    );

    // Save FIFO model: 1-cycle read latency, tags from occupancy, full tag forceable.
    logic [7:0] mem [0:1023];
    int         wp, rp, cnt;
    logic [7:0] fifoQ;
    bit         forceFull = 1'b0;
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wp <= 0; rp <= 0; cnt <= 0; fifoQ <= 8'h00;
        end else begin
            if (oFifoEn[1] && cnt < 1024) begin
                mem[wp] <= oFifoData;
                wp <= (wp + 1) % 1024;
            end
            if (oFifoEn[0] && cnt > 0) begin
                fifoQ <= mem[rp];
                rp <= (rp + 1) % 1024;
            end
            cnt <= cnt + ((oFifoEn[1] && cnt < 1024) ? 1 : 0) - ((oFifoEn[0] && cnt > 0) ? 1 : 0);
        end
    end
    assign iFifoData = fifoQ;
    assign iFifoTag  = {forceFull || (cnt == 1024), cnt == 0};

    int         tests = 0;
    int         fails = 0;
    logic [7:0] expQ [$];
    int         popTotal = 0;
    int         doneCount = 0;
    int         gaps = 0;
    int         gapBase = 0;
    bit         gapArm = 1'b0;
    int         lvlA = 0;
    int         lvlB = 0;
    logic [7:0] expByte;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Consumer scoreboard: every accepted byte must be the oldest byte written.
    always @(negedge CLOCK) begin
        if (RESET) begin
            if (oDone) doneCount++;
            if (gapArm && (popTotal - gapBase) > 0 && (popTotal - gapBase) < 512 && !oValid) gaps++;
            if (oValid && iReady) begin
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pop_unexpected: got byte %0d, required no byte", oData);
                end else begin
                    expByte = expQ.pop_front();
                    check("pop_data", oData, expByte);
                end
                popTotal++;
            end
        end
    end

    task automatic stepCycle();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic doReset();
        RESET = 1'b0; iCall = 1'b0; iSdValid = 1'b0; iReady = 1'b0; forceFull = 1'b0;
        #3;
        expQ.delete();
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic sendBytes(input int n, input int base, input bit randReady);
        for (int i = 0; i < n; i++) begin
            iSdValid = 1'b1;
            iSdData  = 8'(base + i);
            expQ.push_back(8'(base + i));
            if (randReady) iReady = 1'($urandom_range(0, 1));
            if (i == 100) lvlA = int'(oLevel);
            if (i == 400) lvlB = int'(oLevel);
            stepCycle();
        end
        iSdValid = 1'b0;
    endtask

    // Raise iCall and return in the first STREAM cycle (one cycle after oSdCall appears).
    task automatic startSector(input int bound);
        bit ok;
        ok = 1'b0;
        iCall = 1'b1;
        for (int c = 0; c < bound; c++) begin
            @(negedge CLOCK);
            if (oSdCall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL sd_call_timeout: oSdCall=0 after %0d cycles, required 1", bound);
        end
        @(posedge CLOCK);
        #1;
        iCall = 1'b0;
    endtask

    task automatic waitDrain(input int bound);
        bit ok;
        ok = 1'b0;
        iReady = 1'b1;
        for (int c = 0; c < bound; c++) begin
            @(negedge CLOCK);
            if (expQ.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d bytes outstanding, required 0", expQ.size());
        end
        stepCycle();
    endtask

    typedef struct {
        bit         call;
        bit         sdValid;
        logic [7:0] data;
        bit         full;
        bit         expWr;
        bit         expSdCall;
        bit         expErr;
    } vec_t;

    vec_t tbl [10];
    int   doneBase;
    int   popBase;
    int   held;

    initial begin
        #2 RESET = 1'b0;
        #10;
        check("rst_oDone", oDone, 0);
        check("rst_oSdCall", oSdCall, 0);
        check("rst_oFifoEn", oFifoEn, 0);
        check("rst_oValid", oValid, 0);
        check("rst_oData", oData, 0);
        check("rst_oLevel", oLevel, 0);
        check("rst_oErr", oErr, 0);
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;

        // IDLE strobes ignored, call -> WAIT_ROOM -> REQ -> STREAM, forced-full strobe.
        tbl[0] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1};
        doneBase = doneCount;
        for (int i = 0; i < 10; i++) begin
            iCall = tbl[i].call; iSdValid = tbl[i].sdValid;
            iSdData = tbl[i].data; forceFull = tbl[i].full;
            if (tbl[i].expWr) expQ.push_back(tbl[i].data);
            @(negedge CLOCK);
            check($sformatf("vec%0d_wr", i), oFifoEn[1], int'(tbl[i].expWr));
            check($sformatf("vec%0d_sdcall", i), oSdCall, int'(tbl[i].expSdCall));
            check($sformatf("vec%0d_err", i), oErr, int'(tbl[i].expErr));
            if (tbl[i].expWr) check($sformatf("vec%0d_wdata", i), oFifoData, int'(tbl[i].data));
            stepCycle();
        end
        iCall = 1'b0; iSdValid = 1'b0; forceFull = 1'b0;

        // 3 bytes counted so far; 509 more complete the sector, then a stray strobe in DONE.
        sendBytes(509, 8'h40, 1'b0);
        iSdValid = 1'b1; iSdData = 8'hEE;
        @(negedge CLOCK);
        check("done_pulse", oDone, 1);
        check("post_sector_strobe_wr", oFifoEn[1], 0);
        stepCycle();
        iSdValid = 1'b0;
        repeat (5) stepCycle();
        check("done_count_b", doneCount - doneBase, 1);
        check("level_511_written", oLevel, 509);
        check("valid_held", oValid, 1);
        check("head_byte", oData, 8'h11);
        check("err_sticky", oErr, 1);
        waitDrain(2000);
        check("drained_level", oLevel, 0);
        check("drained_valid", oValid, 0);
        check("err_sticky_after_drain", oErr, 1);
        doReset();
        check("err_cleared", oErr, 0);

        // Three sectors with the consumer stalled; the third waits for room.
        doneBase = doneCount;
        startSector(50);
        sendBytes(512, 8'h01, 1'b0);
        repeat (5) stepCycle();
        check("sector1_done", doneCount - doneBase, 1);
        check("sector1_level", oLevel, 510);
        check("sector1_valid", oValid, 1);
        check("sector1_byte0", oData, 8'h01);
        startSector(50);
        sendBytes(512, 8'h80, 1'b0);
        repeat (5) stepCycle();
        check("sector2_level", oLevel, 1022);
        iCall = 1'b1;
        held = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLOCK);
            if (oSdCall) held++;
            stepCycle();
        end
        check("wait_room_hold", held, 0);
        check("wait_room_level", oLevel, 1022);
        iReady = 1'b1;
        startSector(1000);
        check("req_room_level", int'(oLevel <= 11'(ROOM_MAX)), 1);
        sendBytes(512, 8'h30, 1'b0);
        check("level_const_wr_rd", lvlB, lvlA);
        waitDrain(3000);
        check("sector3_done", doneCount - doneBase, 3);
        check("three_sector_level", oLevel, 0);

        // Full-rate drain from empty: no bubbles once the first byte appears.
        doReset();
        iReady = 1'b1;
        popBase = popTotal;
        gapBase = popTotal;
        gaps = 0;
        gapArm = 1'b1;
        startSector(50);
        sendBytes(512, 8'h07, 1'b0);
        waitDrain(100);
        gapArm = 1'b0;
        check("fullrate_pops", popTotal - popBase, 512);
        check("fullrate_gaps", gaps, 0);
        check("fullrate_level", oLevel, 0);
        check("fullrate_valid", oValid, 0);

        // Random consumer stalls while a sector streams in.
        doReset();
        popBase = popTotal;
        startSector(50);
        sendBytes(512, 8'h5A, 1'b1);
        waitDrain(2000);
        check("random_pops", popTotal - popBase, 512);
        check("random_level", oLevel, 0);

        // Reset asserted at byte 200 of the stream.
        doReset();
        doneBase = doneCount;
        startSector(50);
        sendBytes(200, 8'h99, 1'b0);
        iSdValid = 1'b1; iSdData = 8'h12;
        #2 RESET = 1'b0;
        #1;
        check("midrst_oDone", oDone, 0);
        check("midrst_oSdCall", oSdCall, 0);
        check("midrst_oFifoEn", oFifoEn, 0);
        check("midrst_oValid", oValid, 0);
        check("midrst_oData", oData, 0);
        check("midrst_oLevel", oLevel, 0);
        check("midrst_oErr", oErr, 0);
        expQ.delete();
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        @(negedge CLOCK);
        check("midrst_idle_strobe", oFifoEn[1], 0);
        stepCycle();
        iSdValid = 1'b0;
        repeat (3) stepCycle();
        check("midrst_no_done", doneCount - doneBase, 0);
        check("midrst_sdcall_idle", oSdCall, 0);
        check("midrst_level_idle", oLevel, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
